bank_pager: RTL and testbench

Memory-paging unit for the Spectrum-class system. It replaces the fixed combinational address decoder with a parametrised, 128K-style bank mapper. It holds a CPU-writable page register at a decoded I/O port and maps the 64 KiB Z80 space onto ROM and RAM 8 KiB banks. It also provides a lock bit and a frame-synchronised video-page select. It sits between the Z80 bus and the ROM/RAM/video-RAM instances.

---
 rtl/bank_pager.sv | 94 +++++++++
 tb/tb_bank_pager.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_pager.sv
// bank_pager: 128K-style memory pager for a Spectrum-class Z80 system.
// Holds a CPU-writable page register behind a decoded I/O port, maps the
// 64 KiB address space onto 8 KiB ROM/RAM banks, and provides a paging lock
// plus a frame-synchronised video page select.
module bank_pager #(
  parameter int          NUM_BANKS  = 16,
  parameter logic [15:0] PORT_MASK  = 16'h8002,
  parameter logic [15:0] PORT_MATCH = 16'h0000,
  parameter bit          READBACK   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mreq_n,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic [15:0]          ad,
  input  logic [7:0]           din,
  input  logic                 frame_strobe,
  output logic [7:0]           dout,
  output logic                 dout_oe,
  output logic [3:0]           rom_cs,
  output logic [NUM_BANKS-1:0] ram_cs,
  output logic                 port_cs,
  output logic                 locked,
  output logic                 vid_page
);

  // Bank index width; a 16 KiB page number is one bit narrower.
  localparam int BW = $clog2(NUM_BANKS);

  logic [7:0]    pr;
  logic          armed;
  logic          port_hit;
  logic          write_en;
  logic [4:0]    page_full;
  logic [BW-1:0] bank;

  assign port_hit  = ((ad & PORT_MASK) == PORT_MATCH) && !iorq_n;
  assign write_en  = port_hit && !wr_n && armed && !pr[5];
  assign page_full = {pr[7:6], pr[2:0]};

  assign port_cs = port_hit;
  assign locked  = pr[5];
  assign dout    = pr;
  assign dout_oe = READBACK && port_hit && !rd_n;

  // Page register capture; armed makes a long write strobe count only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pr    <= 8'h00;
      armed <= 1'b1;
    end else if (write_en) begin
      pr    <= din;
      armed <= 1'b0;
    end else if (wr_n) begin
      armed <= 1'b1;
    end
  end

  // Screen flips only at frame start, using the register value before any same-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_page <= 1'b0;
    end else if (frame_strobe) begin
      vid_page <= pr[3];
    end
  end

  // Slot decode: one chip select during a memory cycle, none otherwise.
  always_comb begin
    rom_cs = '0;
    ram_cs = '0;
    bank   = '0;
    if (!mreq_n) begin
      unique case (ad[15:14])
        2'b00: rom_cs[{pr[4], ad[13]}] = 1'b1;
        2'b01: begin
          bank         = BW'({4'd5, ad[13]});
          ram_cs[bank] = 1'b1;
        end
        2'b10: begin
          bank         = BW'({4'd2, ad[13]});
          ram_cs[bank] = 1'b1;
        end
        2'b11: begin
          bank         = BW'({page_full, ad[13]});
          ram_cs[bank] = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_pager.sv
// tb_bank_pager: table-driven bench with a scoreboard queue for bank_pager.
// Three instances share one bus: default (16 banks), 64 banks, and write-only port.
module tb_bank_pager;

  typedef struct {
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic [15:0] ad;
    int          rom_idx;
    int          ram_idx;
    int          ram64_idx;
    logic        port;
    logic        oe;
  } vec_t;

  typedef struct {
    string       tag;
    logic [63:0] rom;
    logic [63:0] ram16;
    logic [63:0] ram64;
    logic        port;
    logic        oe;
    logic [7:0]  dout;
    logic        locked;
    logic        vid;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_n, iorq_n, rd_n, wr_n, frame_strobe;
  logic [15:0] ad;
  logic [7:0]  din;

  logic [7:0]  a_dout, b_dout, c_dout;
  logic        a_oe, b_oe, c_oe;
  logic [3:0]  a_rom, b_rom, c_rom;
  logic [15:0] a_ram, c_ram;
  logic [63:0] b_ram;
  logic        a_port, b_port, c_port;
  logic        a_locked, b_locked, c_locked;
  logic        a_vid, b_vid, c_vid;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] pr_m;
  logic       vid_m;

  bank_pager dut (
    .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .ad(ad), .din(din), .frame_strobe(frame_strobe),
    .dout(a_dout), .dout_oe(a_oe), .rom_cs(a_rom), .ram_cs(a_ram),
    .port_cs(a_port), .locked(a_locked), .vid_page(a_vid)
  );

  bank_pager #(.NUM_BANKS(64)) dut64 (
    .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .ad(ad), .din(din), .frame_strobe(frame_strobe),
    .dout(b_dout), .dout_oe(b_oe), .rom_cs(b_rom), .ram_cs(b_ram),
    .port_cs(b_port), .locked(b_locked), .vid_page(b_vid)
  );

  bank_pager #(.READBACK(1'b0)) dut_wo (
    .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .ad(ad), .din(din), .frame_strobe(frame_strobe),
    .dout(c_dout), .dout_oe(c_oe), .rom_cs(c_rom), .ram_cs(c_ram),
    .port_cs(c_port), .locked(c_locked), .vid_page(c_vid)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] oh(input int idx);
    if (idx < 0) return 64'd0;
    return 64'd1 << idx;
  endfunction

  function automatic vec_t mk(input logic m, input logic io, input logic r,
                              input logic [15:0] a, input int rom, input int ram,
                              input int ram64, input logic p, input logic o);
    vec_t v;
    v.mreq_n = m; v.iorq_n = io; v.rd_n = r; v.ad = a;
    v.rom_idx = rom; v.ram_idx = ram; v.ram64_idx = ram64;
    v.port = p; v.oe = o;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idleBus();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    ad = 16'h0000; frame_strobe = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard actual=empty required=entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".a.rom"},    64'(a_rom),    e.rom);
    cmp({e.tag, ".a.ram"},    64'(a_ram),    e.ram16);
    cmp({e.tag, ".a.port"},   64'(a_port),   64'(e.port));
    cmp({e.tag, ".a.oe"},     64'(a_oe),     64'(e.oe));
    cmp({e.tag, ".a.dout"},   64'(a_dout),   64'(e.dout));
    cmp({e.tag, ".a.locked"}, 64'(a_locked), 64'(e.locked));
    cmp({e.tag, ".a.vid"},    64'(a_vid),    64'(e.vid));
    cmp({e.tag, ".b.rom"},    64'(b_rom),    e.rom);
    cmp({e.tag, ".b.ram"},    b_ram,         e.ram64);
    cmp({e.tag, ".b.port"},   64'(b_port),   64'(e.port));
    cmp({e.tag, ".b.oe"},     64'(b_oe),     64'(e.oe));
    cmp({e.tag, ".b.dout"},   64'(b_dout),   64'(e.dout));
    cmp({e.tag, ".b.locked"}, 64'(b_locked), 64'(e.locked));
    cmp({e.tag, ".b.vid"},    64'(b_vid),    64'(e.vid));
    cmp({e.tag, ".c.rom"},    64'(c_rom),    e.rom);
    cmp({e.tag, ".c.ram"},    64'(c_ram),    e.ram16);
    cmp({e.tag, ".c.port"},   64'(c_port),   64'(e.port));
    cmp({e.tag, ".c.oe"},     64'(c_oe),     64'd0);
    cmp({e.tag, ".c.dout"},   64'(c_dout),   64'(e.dout));
    cmp({e.tag, ".c.locked"}, 64'(c_locked), 64'(e.locked));
    cmp({e.tag, ".c.vid"},    64'(c_vid),    64'(e.vid));
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    mreq_n = v.mreq_n; iorq_n = v.iorq_n; rd_n = v.rd_n; wr_n = 1'b1;
    ad = v.ad; frame_strobe = 1'b0;
    e.tag = tag;
    e.rom = oh(v.rom_idx);
    e.ram16 = oh(v.ram_idx);
    e.ram64 = oh(v.ram64_idx);
    e.port = v.port;
    e.oe = v.oe;
    e.dout = pr_m;
    e.locked = pr_m[5];
    e.vid = vid_m;
    sb.push_back(e);
    #2;
    checkOutput();
  endtask

  task automatic runRange(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) applyStimulus(vecs[i], $sformatf("%s%0d", tag, i));
  endtask

  // Port write with wr_n held for 'hold' edges; din is scrambled after the first edge.
  task automatic ioWrite(input logic [15:0] a, input logic [7:0] d, input int hold,
                         input logic strobe);
    @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    ad = a; din = d; frame_strobe = strobe;
    @(negedge clk);
    frame_strobe = 1'b0;
    din = ~d;
    repeat (hold - 1) @(negedge clk);
    idleBus();
  endtask

  task automatic frameStrobe();
    @(negedge clk);
    frame_strobe = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
  endtask

  // Main sequence: tables per page-register state plus hand-written corner cases.
  initial begin
    // Phase A, pr = 0x00 (rows 0..12)
    vecs.push_back(mk(0, 1, 0, 16'hC000, -1,  0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000,  0, -1, -1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4000, -1, 10, 10, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h8000, -1,  4,  4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h2000,  1, -1, -1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h6000, -1, 11, 11, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'hA000, -1,  5,  5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'hE000, -1,  1,  1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 16'hC000, -1, -1, -1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h7FFD, -1, -1, -1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 16'h7FFF, -1, -1, -1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'hFFFD, -1, -1, -1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h7FFD, -1, -1, -1, 1, 0));
    // Phase B, pr = 0x13: page 3, rom_sel 1 (rows 13..19)
    vecs.push_back(mk(0, 1, 0, 16'hC000, -1,  6,  6, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'hE000, -1,  7,  7, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000,  2, -1, -1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h2000,  3, -1, -1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4000, -1, 10, 10, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h8000, -1,  4,  4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h7FFD, -1, -1, -1, 1, 1));
    // Phase C, pr = 0x21 locked: page 1, rom_sel 0 (rows 20..24)
    vecs.push_back(mk(0, 1, 0, 16'hC000, -1,  2,  2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'hE000, -1,  3,  3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000,  0, -1, -1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h2000,  1, -1, -1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h7FFD, -1, -1, -1, 1, 1));
    // Phase D, pr = 0xC7: page 7 with 16 banks, page 31 with 64 (rows 25..28)
    vecs.push_back(mk(0, 1, 0, 16'hC000, -1, 14, 62, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'hE000, -1, 15, 63, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000,  0, -1, -1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4000, -1, 10, 10, 0, 0));

    reset = 1'b1;
    din = 8'h00;
    idleBus();
    pr_m = 8'h00;
    vid_m = 1'b0;
    repeat (2) @(negedge clk);
    runRange(8, 8, "RST");
    @(negedge clk);
    reset = 1'b0;

    runRange(0, 12, "A");

    ioWrite(16'h7FFD, 8'h13, 3, 1'b0);
    pr_m = 8'h13;
    runRange(13, 19, "B");

    ioWrite(16'h7FFD, 8'h08, 1, 1'b0);
    pr_m = 8'h08;
    runRange(8, 8, "V0_");
    frameStrobe();
    vid_m = 1'b1;
    runRange(8, 8, "V1_");

    ioWrite(16'h7FFD, 8'h00, 1, 1'b1);
    pr_m = 8'h00;
    runRange(8, 8, "V2_");
    frameStrobe();
    vid_m = 1'b0;
    runRange(8, 8, "V3_");

    ioWrite(16'h7FFD, 8'h21, 1, 1'b0);
    ioWrite(16'h7FFD, 8'h06, 1, 1'b0);
    pr_m = 8'h21;
    runRange(20, 24, "C");

    @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    ad = 16'h7FFD; din = 8'h15; reset = 1'b1;
    #1;
    cmp("rst.mid.dout", 64'(a_dout), 64'h00);
    cmp("rst.mid.locked", 64'(a_locked), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idleBus();
    pr_m = 8'h15;
    runRange(9, 10, "R");

    ioWrite(16'h7FFD, 8'hC7, 1, 1'b0);
    pr_m = 8'hC7;
    runRange(25, 28, "D");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
